// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - BTB entry type, direction-counter encodings and index/tag width helpers
package fetch_pkg;

  // Entry fields are sized for the widest supported PC; upper bits stay zero.
  localparam int unsigned FP_MAX_W = 64;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef struct packed {
    logic                valid;
    logic [FP_MAX_W-1:0] tag;
    logic [FP_MAX_W-1:0] target;
    logic [1:0]          ctr;
  } btb_entry_t;

  function automatic int unsigned fp_idx_w(input int unsigned depth);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < depth) w = w + 1;
    return w;
  endfunction

  function automatic int unsigned fp_tag_w(input int unsigned data_w, input int unsigned depth);
    return data_w - 2 - fp_idx_w(depth);
  endfunction

endpackage

// File: rtl/fetch_predictor_r1_btb.sv
// rtl/fetch_predictor_r1_btb.sv - direct-mapped BTB with 2-bit counters (module btb_r1)
module btb_r1
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BTB_DEPTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en_n,
  input  logic [DATA_WIDTH-3:0] i_lk_word,
  output logic                  o_pred_taken,
  output logic [DATA_WIDTH-1:0] o_pred_target,
  input  logic                  i_upd_valid,
  input  logic [DATA_WIDTH-3:0] i_upd_word,
  input  logic [DATA_WIDTH-1:0] i_upd_target,
  input  logic                  i_upd_taken
);
  localparam int unsigned IDX_W = fp_idx_w(BTB_DEPTH);
  localparam int unsigned TAG_W = fp_tag_w(DATA_WIDTH, BTB_DEPTH);

  btb_entry_t       r_mem [BTB_DEPTH];
  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_lk_hit;
  logic             w_up_hit;
  logic [1:0]       w_up_ctr;

  assign w_lk_idx = i_lk_word[IDX_W-1:0];
  assign w_lk_tag = i_lk_word[DATA_WIDTH-3:IDX_W];
  assign w_up_idx = i_upd_word[IDX_W-1:0];
  assign w_up_tag = i_upd_word[DATA_WIDTH-3:IDX_W];

  // Lookup reads the array directly, so a same-cycle update is not yet visible.
  assign w_lk_hit      = r_mem[w_lk_idx].valid && (r_mem[w_lk_idx].tag == FP_MAX_W'(w_lk_tag));
  assign o_pred_taken  = w_lk_hit && r_mem[w_lk_idx].ctr[1];
  assign o_pred_target = DATA_WIDTH'(r_mem[w_lk_idx].target);

  assign w_up_hit = r_mem[w_up_idx].valid && (r_mem[w_up_idx].tag == FP_MAX_W'(w_up_tag));
  assign w_up_ctr = r_mem[w_up_idx].ctr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(BTB_DEPTH); i++) begin
        r_mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (!i_en_n && i_upd_valid) begin
      if (w_up_hit) begin
        if (i_upd_taken) begin
          r_mem[w_up_idx].ctr    <= (w_up_ctr == CTR_ST) ? CTR_ST : w_up_ctr + 2'd1;
          r_mem[w_up_idx].target <= FP_MAX_W'(i_upd_target);
        end else begin
          r_mem[w_up_idx].ctr <= (w_up_ctr == CTR_SNT) ? CTR_SNT : w_up_ctr - 2'd1;
        end
      end else if (i_upd_taken) begin
        r_mem[w_up_idx] <= '{valid: 1'b1, tag: FP_MAX_W'(w_up_tag),
                             target: FP_MAX_W'(i_upd_target), ctr: CTR_WT};
      end
    end
  end

endmodule

// File: rtl/fetch_predictor_r1.sv
// rtl/fetch_predictor_r1.sv - fetch PC register with BTB-driven next-PC selection
// Optional build macro BP_STATS_EN adds saturating stat_pred / stat_redir counters.
module fetch_predictor_r1
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           BTB_DEPTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_n,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  upd_valid,
  input  logic [DATA_WIDTH-1:0] upd_pc,
  input  logic [DATA_WIDTH-1:0] upd_target,
  input  logic                  upd_taken,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target
`ifdef BP_STATS_EN
  ,
  output logic [31:0]           stat_pred,
  output logic [31:0]           stat_redir
`endif
);
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_next_pc;
  logic [DATA_WIDTH-1:0] w_pred_target;
  logic                  w_pred_taken;
  logic                  w_unused_lsbs;

  // Byte offset of the branch PC plays no part in BTB indexing.
  assign w_unused_lsbs = ^upd_pc[1:0];

  btb_r1 #(
    .DATA_WIDTH(DATA_WIDTH),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en_n       (en_n),
    .i_lk_word    (r_pc[DATA_WIDTH-1:2]),
    .o_pred_taken (w_pred_taken),
    .o_pred_target(w_pred_target),
    .i_upd_valid  (upd_valid),
    .i_upd_word   (upd_pc[DATA_WIDTH-1:2]),
    .i_upd_target (upd_target),
    .i_upd_taken  (upd_taken)
  );

  always_comb begin
    w_next_pc = r_pc + DATA_WIDTH'(4);
    if (redirect) begin
      w_next_pc = redirect_pc;
    end else if (stall) begin
      w_next_pc = r_pc;
    end else if (w_pred_taken) begin
      w_next_pc = w_pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (!en_n) begin
      r_pc <= w_next_pc;
    end
  end

  assign pc          = r_pc;
  assign pred_taken  = w_pred_taken;
  assign pred_target = w_pred_target;

`ifdef BP_STATS_EN
  logic [31:0] r_stat_pred;
  logic [31:0] r_stat_redir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_pred  <= '0;
      r_stat_redir <= '0;
    end else if (!en_n) begin
      if (w_pred_taken && !stall && !redirect && (r_stat_pred != 32'hFFFF_FFFF)) begin
        r_stat_pred <= r_stat_pred + 32'd1;
      end
      if (redirect && (r_stat_redir != 32'hFFFF_FFFF)) begin
        r_stat_redir <= r_stat_redir + 32'd1;
      end
    end
  end

  assign stat_pred  = r_stat_pred;
  assign stat_redir = r_stat_redir;
`endif

endmodule

// File: tb/tb_fetch_predictor_r1.sv
// tb/tb_fetch_predictor_r1.sv - randomized self-checking bench with a behavioural BTB model
module tb_fetch_predictor_r1;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [31:0] upd_target = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
`ifdef BP_STATS_EN
  logic [31:0] stat_pred;
  logic [31:0] stat_redir;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_predictor_r1 #(
    .DATA_WIDTH(32),
    .BTB_DEPTH (16),
    .RESET_PC  (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_n       (en_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .pc         (pc),
    .pred_taken (pred_taken),
    .pred_target(pred_target)
`ifdef BP_STATS_EN
    ,
    .stat_pred  (stat_pred),
    .stat_redir (stat_redir)
`endif
  );

  // Reference model: a table of known branches keyed by word index, plus the fetch PC.
  bit          m_v   [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];
  logic [31:0] m_pc;
  longint      m_sp;
  longint      m_sr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i]   = 1'b0;
      m_ctr[i] = 1;
    end
    m_pc = 32'h0;
    m_sp = 0;
    m_sr = 0;
  endfunction

  function automatic int m_slot(input logic [31:0] p);
    return int'((p / 4) % 16);
  endfunction

  function automatic bit m_known(input logic [31:0] p);
    return m_v[m_slot(p)] && (m_tag[m_slot(p)] == int'(p / 64));
  endfunction

  function automatic void m_update(input logic [31:0] p, input logic [31:0] t, input bit tk);
    int s;
    s = m_slot(p);
    if (m_known(p)) begin
      if (tk) begin
        m_ctr[s] = (m_ctr[s] >= 3) ? 3 : m_ctr[s] + 1;
        m_tgt[s] = t;
      end else begin
        m_ctr[s] = (m_ctr[s] <= 0) ? 0 : m_ctr[s] - 1;
      end
    end else if (tk) begin
      m_v[s]   = 1'b1;
      m_tag[s] = int'(p / 64);
      m_tgt[s] = t;
      m_ctr[s] = 2;
    end
  endfunction

  task automatic drive(input bit e, input bit s, input bit r, input logic [31:0] rp,
                       input bit uv, input logic [31:0] up, input logic [31:0] ut, input bit tk);
    en_n = e; stall = s; redirect = r; redirect_pc = rp;
    upd_valid = uv; upd_pc = up; upd_target = ut; upd_taken = tk;
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic tick(input string tag);
    bit          pt;
    logic [31:0] nxt;
    #2;
    pt = m_known(m_pc) && (m_ctr[m_slot(m_pc)] >= 2);
    check({tag, ":pred_taken"}, pred_taken, pt);
    if (pt) check({tag, ":pred_target"}, pred_target, m_tgt[m_slot(m_pc)]);
    if (en_n) nxt = m_pc;
    else if (redirect) nxt = redirect_pc;
    else if (stall) nxt = m_pc;
    else if (pt) nxt = m_tgt[m_slot(m_pc)];
    else nxt = m_pc + 32'd4;
    if (!en_n) begin
      if (pt && !stall && !redirect) m_sp++;
      if (redirect) m_sr++;
      if (upd_valid) m_update(upd_pc, upd_target, upd_taken);
    end
    @(posedge clk);
    #1;
    m_pc = nxt;
    check({tag, ":pc"}, pc, m_pc);
`ifdef BP_STATS_EN
    check({tag, ":stat_pred"}, stat_pred, m_sp);
    check({tag, ":stat_redir"}, stat_redir, m_sr);
`endif
  endtask

  task automatic go(input logic [31:0] p);
    drive(0, 0, 1, p, 0, 0, 0, 0);
    tick("goto");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] p, input logic [31:0] t, input bit tk);
    drive(0, 0, 0, 0, 1, p, t, tk);
    tick("upd");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    m_reset();
    check({tag, ":async_pc"}, pc, 32'h0);
    check({tag, ":async_pred"}, pred_taken, 1'b0);
`ifdef BP_STATS_EN
    check({tag, ":stat_pred0"}, stat_pred, 32'h0);
    check({tag, ":stat_redir0"}, stat_redir, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check({tag, ":release_pc"}, pc, 32'h0);
  endtask

  logic [31:0] hold_pc;

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_pc", pc, 32'h0);
    check("reset_pred", pred_taken, 1'b0);

    repeat (16) tick("idle");
    check("run_to_40", pc, 32'h40);

    // Reset lands on top of a pending allocation, which must be dropped.
    drive(0, 0, 0, 0, 1, 32'h40, 32'h300, 1);
    async_reset("rst1");
    tick("post_rst");
    check("post_rst_4", pc, 32'h4);
    tick("post_rst");
    check("post_rst_8", pc, 32'h8);
    repeat (14) tick("idle");

    go(32'h10);
    drive(0, 0, 0, 0, 1, 32'h10, 32'h80, 1);
    check("same_cycle_lookup", pred_taken, 1'b0);
    tick("alloc");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    go(32'h10);
    check("alloc_pred", pred_taken, 1'b1);
    check("alloc_target", pred_target, 32'h80);
    tick("follow");
    check("alloc_next", pc, 32'h80);

    upd(32'h10, 32'h80, 0);
    go(32'h10);
    check("weak_nt_pred", pred_taken, 1'b0);
    tick("fallthru");
    check("weak_nt_next", pc, 32'h14);
    repeat (3) upd(32'h10, 32'h80, 1);
    upd(32'h10, 32'h80, 0);
    go(32'h10);
    check("hyst_pred", pred_taken, 1'b1);
    tick("hyst");

    go(32'h50);
    check("alias_pred", pred_taken, 1'b0);
    tick("alias");
    check("alias_next", pc, 32'h54);
    upd(32'h50, 32'h100, 1);
    go(32'h10);
    check("evicted_pred", pred_taken, 1'b0);
    go(32'h50);
    check("evictor_pred", pred_taken, 1'b1);
    check("evictor_target", pred_target, 32'h100);

    hold_pc = m_pc;
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) tick("stall");
    check("stall_hold", pc, hold_pc);
    drive(0, 1, 1, 32'h200, 0, 0, 0, 0);
    tick("stall_redir");
    check("stall_redir_pc", pc, 32'h200);
    drive(1, 0, 1, 32'h300, 1, 32'h200, 32'h8, 1);
    tick("en_n_hold");
    check("en_n_hold_pc", pc, 32'h200);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick("after_en_n");

    for (int n = 0; n < 800; n++) begin
      logic [31:0] rp;
      rp = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 15) == 0) rp = rp | 32'($urandom_range(0, 3));
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, rp, $urandom_range(0, 1) == 1,
            32'($urandom_range(0, 63)) << 2, 32'($urandom_range(0, 255)) << 2,
            $urandom_range(0, 2) != 0);
      tick("rand");
      if (n == 400) begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        async_reset("rst2");
      end
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    async_reset("rst3");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
